// File: rtl/fifo_pkg.sv
// Shared defaults for the single-clock FIFO: word width, depth and derived widths.
package fifo_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int DEPTH_DEF      = 16;
    localparam int ADDR_WIDTH_DEF = $clog2(DEPTH_DEF);
    // One extra wrap bit distinguishes full from empty when the index bits match.
    localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port register array: synchronous write, registered read with enable.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the output register is reset; the array contents are left as-is.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: wrap-bit pointers, register-derived full/empty, one-cycle
// overflow/underflow pulses on rejected requests.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int DEPTH      = DEPTH_DEF,
    parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wen,
    input  logic                  ren,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int PTR_W = ADDR_WIDTH + 1;

    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             wr_ok;
    logic             rd_ok;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[ADDR_WIDTH-1:0] == rptr_q[ADDR_WIDTH-1:0]) &&
                   (wptr_q[ADDR_WIDTH] != rptr_q[ADDR_WIDTH]);

    // Both decisions use the pre-edge flags, so a same-edge read never makes
    // room for a write when full, and a write never feeds a read when empty.
    assign wr_ok = wen && !full;
    assign rd_ok = ren && !empty;

    always_comb begin
        wptr_d      = wptr_q;
        rptr_d      = rptr_q;
        overflow_d  = wen && full;
        underflow_d = ren && empty;
        if (wr_ok) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (rd_ok) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q      <= '0;
            rptr_q      <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wptr_q      <= wptr_d;
            rptr_q      <= rptr_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    fifo_mem #(
        .DATA_WIDTH(DATA_WIDTH),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_mem (
        .clk_i   (clk),
        .rst_ni  (rst),
        .we_i    (wr_ok),
        .waddr_i (wptr_q[ADDR_WIDTH-1:0]),
        .wdata_i (wr_data),
        .re_i    (rd_ok),
        .raddr_i (rptr_q[ADDR_WIDTH-1:0]),
        .rdata_o (rd_data)
    );

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (8 bits x 16 entries).
module tb_sync_fifo;

    logic       clk;
    logic       rst;
    logic       wen;
    logic       ren;
    logic [7:0] wr_data;
    logic [7:0] rd_data;
    logic       full;
    logic       empty;
    logic       overflow;
    logic       underflow;

    int n_cmp;
    int n_bad;

    sync_fifo dut (
        .clk       (clk),
        .rst       (rst),
        .wen       (wen),
        .ren       (ren),
        .wr_data   (wr_data),
        .rd_data   (rd_data),
        .full      (full),
        .empty     (empty),
        .overflow  (overflow),
        .underflow (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Apply one set of requests across a rising edge, then settle 1 time unit.
    task automatic step(input logic w, input logic r, input logic [7:0] d);
        wen     = w;
        ren     = r;
        wr_data = d;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] model_q[$];
    logic [7:0] exp_rd;

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst     = 1'b0;
        wen     = 1'b1;
        ren     = 1'b1;
        wr_data = 8'h55;
        exp_rd  = 8'h00;

        // Reset held with both requests active
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_underflow", 32'(underflow), 32'd0);
        wen = 1'b0;
        ren = 1'b0;
        rst = 1'b1;

        // Streaming: write+read every edge
        step(1'b1, 1'b1, 8'h8F);
        check("stream0_underflow", 32'(underflow), 32'd1);
        check("stream0_empty", 32'(empty), 32'd0);
        check("stream0_rd_data", 32'(rd_data), 32'h00);
        step(1'b1, 1'b1, 8'hFF);
        check("stream1_rd_data", 32'(rd_data), 32'h8F);
        check("stream1_underflow", 32'(underflow), 32'd0);
        check("stream1_empty", 32'(empty), 32'd0);
        check("stream1_full", 32'(full), 32'd0);
        step(1'b1, 1'b1, 8'hF9);
        check("stream2_rd_data", 32'(rd_data), 32'hFF);
        step(1'b1, 1'b1, 8'hE1);
        check("stream3_rd_data", 32'(rd_data), 32'hF9);
        check("stream3_empty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("stream4_rd_data", 32'(rd_data), 32'hE1);
        check("stream4_empty", 32'(empty), 32'd1);

        // Fill 16 words, then one rejected write
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i));
            if (i == 14) check("fill15_full", 32'(full), 32'd0);
        end
        check("fill16_full", 32'(full), 32'd1);
        step(1'b1, 1'b0, 8'hAA);
        check("fill17_overflow", 32'(overflow), 32'd1);
        check("fill17_full", 32'(full), 32'd1);
        step(1'b0, 1'b0, 8'h00);
        check("fill_overflow_pulse", 32'(overflow), 32'd0);

        // Drain in order, then one rejected read
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("drain%0d_rd_data", i), 32'(rd_data), 32'(i));
        end
        check("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b1, 8'h00);
        check("drain17_underflow", 32'(underflow), 32'd1);
        check("drain17_rd_data", 32'(rd_data), 32'h0F);
        step(1'b0, 1'b0, 8'h00);
        check("drain_underflow_pulse", 32'(underflow), 32'd0);

        // Full with both requests: read oldest, write dropped
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(8'h20 + i));
        step(1'b1, 1'b1, 8'h77);
        check("fullboth_rd_data", 32'(rd_data), 32'h20);
        check("fullboth_overflow", 32'(overflow), 32'd1);
        check("fullboth_full", 32'(full), 32'd0);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00);
            check($sformatf("fullboth_drain%0d", i), 32'(rd_data), 32'(8'h20 + i));
        end
        check("fullboth_empty", 32'(empty), 32'd1);

        // 40 interleaved transfers across the pointer wrap, against a queue model
        model_q.delete();
        for (int k = 0; k < 40; k++) begin
            logic r;
            r = (k >= 3) && (k % 4 != 0);
            step(1'b1, r, 8'(8'h40 + k));
            if (r) exp_rd = model_q.pop_front();
            model_q.push_back(8'(8'h40 + k));
            if (r) check($sformatf("wrap%0d_rd_data", k), 32'(rd_data), 32'(exp_rd));
            check($sformatf("wrap%0d_flags", k), {30'd0, overflow, underflow}, 32'd0);
        end
        check("wrap_empty", 32'(empty), 32'(model_q.size() == 0));

        // Asynchronous reset mid-cycle
        wen = 1'b1;
        ren = 1'b1;
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_empty", 32'(empty), 32'd1);
        check("async_rst_full", 32'(full), 32'd0);
        check("async_rst_rd_data", 32'(rd_data), 32'h00);
        wen = 1'b0;
        ren = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        step(1'b1, 1'b0, 8'h5A);
        check("post_rst_empty", 32'(empty), 32'd0);
        step(1'b0, 1'b1, 8'h00);
        check("post_rst_rd_data", 32'(rd_data), 32'h5A);
        check("post_rst_empty2", 32'(empty), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
